ca_run_sequencer: RTL and testbench
===================================

Name: ca_run_sequencer

Overview:
Controller for the elementary cellular-automaton cell ring: a WIDTH-cell ring of `cell` instances sharing op and rule, with neighbours sampled on negedge and state updated on posedge. Accepts a run command (rule, seed, generation count), issues INIT then one DOIT per generation, and holds the ring between steps. Each generation's ring state is streamed out over a valid/ready handshake; the ring stays frozen under backpressure. Optional early stop when the ring reaches a fixed point.

Parameters:
WIDTH, 8, number of cells in the ring; width of seed, state and snapshot.
GEN_W, 8, width of the generation count and counter.

Ports:
clk  input  1  clock; all controller logic on posedge.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  run request; sampled only in IDLE.
rule_i  input  8  Wolfram rule number; latched on accepted start.
seed_i  input  WIDTH  initial ring state; latched on accepted start.
gens_i  input  GEN_W  number of DOIT steps to run; latched on accepted start.
stop_on_fixed_i  input  1  enables early stop on fixed point; latched on accepted start.
busy_o  output  1  high in every state except IDLE.
ca_op_o  output  2  ring op: 0 = INIT, 1 = DOIT, 2 = HOLD (no case match in the cell, so state is held).
ca_rule_o  output  8  latched rule, driven to all cells.
ca_seed_o  output  WIDTH  latched seed, driven to the cells' in pins.
ca_state_i  input  WIDTH  ring state vector, bit i = cell i.
out_valid_o  output  1  snapshot available.
out_ready_i  input  1  consumer accepts the snapshot.
out_state_o  output  WIDTH  snapshot of the ring state.
out_gen_o  output  GEN_W  generation index of the snapshot; seed = 0.
fixed_o  output  1  sticky for the run: a snapshot equalled the previous snapshot.
done_o  output  1  one-cycle pulse at the end of a run.

Behaviour:
- All outputs are registered, Moore style. On reset: state IDLE, ca_op_o = 2, every other output 0. Latched rule/seed/gens/stop also clear to 0.
- Reset mid-run aborts immediately to IDLE with HOLD. The ring itself has no reset; every run begins with INIT.
- States:
  - IDLE: op = HOLD. If start_i is high: latch inputs, gen_cnt = 0, clear fixed_o, go to LOAD.
  - LOAD: exactly 1 cycle with op = INIT; the ring loads the seed at the closing posedge. Then go to CAPTURE.
  - CAPTURE: 1 cycle, op = HOLD. snap <= ca_state_i and out_gen_o <= gen_cnt.
    - If gen_cnt != 0 and ca_state_i == snap (old value), set fixed_o.
    - Then go to EMIT.
  - EMIT: op = HOLD, out_valid_o = 1. out_state_o/out_gen_o stay stable until out_valid_o && out_ready_i. On that handshake, out_valid_o drops the next cycle and:
    - if gen_cnt == gens_q, or (stop_q and fixed_o): go to DONE;
    - otherwise go to STEP.
  - STEP: exactly 1 cycle with op = DOIT; gen_cnt++ (wraps only beyond gens_q, so it never wraps in practice). Then go to CAPTURE.
  - DONE: done_o = 1 for 1 cycle, op = HOLD, then IDLE. busy_o drops in the IDLE cycle.
- Cycle counts:
  - Minimum cycles per generation with out_ready_i tied high: 3 (STEP, CAPTURE, EMIT).
  - Full run: start accept → LOAD → CAPTURE → EMIT, then gens × 3, then DONE.
  - Snapshots emitted: gens_q+1, or fewer on a fixed-point stop.
- gens_i = 0: only the seed is emitted, then DONE.
- The fixed-point check compares consecutive generations only; period-2 oscillation is not detected. fixed_o is set even when stop is disabled.
- start_i while busy_o is ignored; the latched values do not change mid-run.
- ca_op_o never carries INIT or DOIT for more than 1 consecutive cycle; the ring advances exactly once per STEP.

Test Plan:
1. Rule 150, seed 00010000, gens 2, ready high → snapshots 00010000 (gen 0), 00111000 (gen 1), 01010100 (gen 2); done_o after the third handshake; fixed_o = 0; exactly 1 INIT and 2 DOIT cycles.
2. Same run with out_ready_i low for 5 cycles in each EMIT → out_valid_o and the snapshot are held stable; ca_op_o = 2 throughout the stall; identical data sequence.
3. Rule 204 (identity), seed 10100101, gens 5, stop_on_fixed 1 → gen 0 and gen 1 both 10100101; fixed_o = 1 after gen 1; done_o; only 1 DOIT issued. Same with stop 0 → 6 snapshots, fixed_o = 1.
4. gens 0, seed 11110000 → one snapshot (gen 0, 11110000), then done_o; no DOIT cycle.
5. Assert rst_n low in the STEP cycle of gen 3 → outputs 0 and ca_op_o = 2 asynchronously. A new start with rule 150, seed 00010000 reproduces scenario 1 from INIT.
6. start_i pulsed with a different rule during EMIT → ignored; the run completes with the original rule; busy_o stays high until the IDLE cycle after done_o.

Source files
------------

// File: rtl/ca_run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ca_run_sequencer                                                         |
// | Drives INIT/DOIT/HOLD into an elementary CA cell ring and streams each   |
// | generation's ring state out over a valid/ready handshake.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ca_run_sequencer #(
  parameter int WIDTH = 8,
  parameter int GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [7:0]       rule_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [GEN_W-1:0] gens_i,
  input  logic             stop_on_fixed_i,
  output logic             busy_o,
  output logic [1:0]       ca_op_o,
  output logic [7:0]       ca_rule_o,
  output logic [WIDTH-1:0] ca_seed_o,
  input  logic [WIDTH-1:0] ca_state_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_state_o,
  output logic [GEN_W-1:0] out_gen_o,
  output logic             fixed_o,
  output logic             done_o
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_load    = 3'd1;
  localparam logic [2:0] c_st_capture = 3'd2;
  localparam logic [2:0] c_st_emit    = 3'd3;
  localparam logic [2:0] c_st_step    = 3'd4;
  localparam logic [2:0] c_st_done    = 3'd5;

  localparam logic [1:0] c_op_init = 2'd0;
  localparam logic [1:0] c_op_doit = 2'd1;
  localparam logic [1:0] c_op_hold = 2'd2;

  logic [2:0]       r_state;
  logic [1:0]       r_op;
  logic             r_busy;
  logic [7:0]       r_rule;
  logic [WIDTH-1:0] r_seed;
  logic [GEN_W-1:0] r_gens;
  logic             r_stop;
  logic [GEN_W-1:0] r_gen_cnt;
  logic [WIDTH-1:0] r_snap;
  logic [GEN_W-1:0] r_out_gen;
  logic             r_fixed;
  logic             r_valid;
  logic             r_done;

  logic w_handshake;
  logic w_finish;

  assign w_handshake = r_valid && out_ready_i;
  assign w_finish    = (r_gen_cnt == r_gens) || (r_stop && r_fixed);

  // op/valid/busy/done are registered against the state being entered so
  // every output is a clean flop and INIT/DOIT last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_op      <= c_op_hold;
      r_busy    <= 1'b0;
      r_rule    <= '0;
      r_seed    <= '0;
      r_gens    <= '0;
      r_stop    <= 1'b0;
      r_gen_cnt <= '0;
      r_snap    <= '0;
      r_out_gen <= '0;
      r_fixed   <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start_i) begin
            r_rule    <= rule_i;
            r_seed    <= seed_i;
            r_gens    <= gens_i;
            r_stop    <= stop_on_fixed_i;
            r_gen_cnt <= '0;
            r_fixed   <= 1'b0;
            r_busy    <= 1'b1;
            r_op      <= c_op_init;
            r_state   <= c_st_load;
          end
        end
        c_st_load: begin
          r_op    <= c_op_hold;
          r_state <= c_st_capture;
        end
        c_st_capture: begin
          r_snap    <= ca_state_i;
          r_out_gen <= r_gen_cnt;
          // Seed has no predecessor, so only later generations can be fixed.
          if ((r_gen_cnt != '0) && (ca_state_i == r_snap)) begin
            r_fixed <= 1'b1;
          end
          r_valid <= 1'b1;
          r_state <= c_st_emit;
        end
        c_st_emit: begin
          if (w_handshake) begin
            r_valid <= 1'b0;
            if (w_finish) begin
              r_done  <= 1'b1;
              r_state <= c_st_done;
            end else begin
              r_op    <= c_op_doit;
              r_state <= c_st_step;
            end
          end
        end
        c_st_step: begin
          r_gen_cnt <= r_gen_cnt + GEN_W'(1);
          r_op      <= c_op_hold;
          r_state   <= c_st_capture;
        end
        c_st_done: begin
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
        default: begin
          r_op    <= c_op_hold;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign ca_op_o     = r_op;
  assign ca_rule_o   = r_rule;
  assign ca_seed_o   = r_seed;
  assign out_valid_o = r_valid;
  assign out_state_o = r_snap;
  assign out_gen_o   = r_out_gen;
  assign fixed_o     = r_fixed;
  assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ca_run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ca_run_sequencer                                                      |
// | Scoreboard bench with a behavioural CA ring and reference model.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ca_run_sequencer;

  localparam int W = 8;
  localparam int G = 8;

  typedef struct packed {
    logic [W-1:0] st;
    logic [G-1:0] gen;
  } snap_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [7:0]   rule_i = '0;
  logic [W-1:0] seed_i = '0;
  logic [G-1:0] gens_i = '0;
  logic         stop_i = 1'b0;
  logic         busy_o;
  logic [1:0]   ca_op_o;
  logic [7:0]   ca_rule_o;
  logic [W-1:0] ca_seed_o;
  logic [W-1:0] ring = 8'h3C;
  logic [W-1:0] ring_nxt = 8'h3C;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [W-1:0] out_state_o;
  logic [G-1:0] out_gen_o;
  logic         fixed_o;
  logic         done_o;

  int    n_checks = 0;
  int    n_pass = 0;
  int    init_cnt = 0;
  int    doit_cnt = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;
  int    vcnt = 0;
  snap_t exp_q[$];

  ca_run_sequencer #(.WIDTH(W), .GEN_W(G)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .rule_i(rule_i),
    .seed_i(seed_i), .gens_i(gens_i), .stop_on_fixed_i(stop_i),
    .busy_o(busy_o), .ca_op_o(ca_op_o), .ca_rule_o(ca_rule_o),
    .ca_seed_o(ca_seed_o), .ca_state_i(ring), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_state_o(out_state_o),
    .out_gen_o(out_gen_o), .fixed_o(fixed_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ca_step(input logic [W-1:0] s, input logic [7:0] rule);
    logic [W-1:0] n;
    logic [2:0]   idx;
    n = '0;
    for (int i = 0; i < W; i++) begin
      idx  = {s[(i + 1) % W], s[i], s[(i + W - 1) % W]};
      n[i] = rule[idx];
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Cell ring: neighbours sampled on negedge, state committed on posedge.
  always @(negedge clk) begin
    case (ca_op_o)
      2'd0:    ring_nxt = ca_seed_o;
      2'd1:    ring_nxt = ca_step(ring, ca_rule_o);
      default: ring_nxt = ring;
    endcase
  end
  always @(posedge clk) ring <= ring_nxt;

  always @(posedge clk) begin
    #1;
    if (out_valid_o) vcnt++;
    else vcnt = 0;
    case (ready_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = 1'($urandom_range(0, 1));
      default: out_ready_i = (vcnt > 5);
    endcase
  end

  // Monitor: scoreboard pops, stall stability, op pulse shape, done pulse.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_st = '0;
  logic [G-1:0] prev_gen = '0;
  logic [1:0]   prev_op = 2'd2;
  logic         prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_op    = 2'd2;
      prev_done  = 1'b0;
    end else begin
      if (ca_op_o == 2'd0) init_cnt++;
      if (ca_op_o == 2'd1) doit_cnt++;
      if (ca_op_o != 2'd2) check("op_single_cycle", 32'(prev_op), 32'd2);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid_o), 32'd1);
        check("stall_state", 32'(out_state_o), 32'(prev_st));
        check("stall_gen", 32'(out_gen_o), 32'(prev_gen));
        check("stall_op", 32'(ca_op_o), 32'd2);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_snapshot", 32'd1, 32'd0);
        end else begin
          snap_t e;
          e = exp_q.pop_front();
          check("snap_state", 32'(out_state_o), 32'(e.st));
          check("snap_gen", 32'(out_gen_o), 32'(e.gen));
        end
      end
      if (done_o) begin
        done_cnt++;
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_pulse", 32'(prev_done), 32'd0);
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_st    = out_state_o;
      prev_gen   = out_gen_o;
      prev_op    = ca_op_o;
      prev_done  = done_o;
    end
  end

  // Reference: whole-run expectations from the CA rule, independent of the FSM.
  task automatic build_expect(input logic [7:0] rule, input logic [W-1:0] seed,
                              input logic [G-1:0] gens, input logic stop,
                              output int doits, output logic fx);
    logic [W-1:0] s;
    logic [W-1:0] prev;
    s = seed; fx = 1'b0; doits = 0;
    for (int g = 0; g <= int'(gens); g++) begin
      if (g > 0) begin
        prev = s;
        s = ca_step(s, rule);
        doits++;
        if (s == prev) fx = 1'b1;
      end
      exp_q.push_back('{st: s, gen: G'(g)});
      if (stop && fx) break;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_op"}, 32'(ca_op_o), 32'd2);
    check({tag, "_rule"}, 32'(ca_rule_o), 32'd0);
    check({tag, "_seed"}, 32'(ca_seed_o), 32'd0);
    check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_state"}, 32'(out_state_o), 32'd0);
    check({tag, "_gen"}, 32'(out_gen_o), 32'd0);
    check({tag, "_fixed"}, 32'(fixed_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  task automatic run(input logic [7:0] rule, input logic [W-1:0] seed,
                     input logic [G-1:0] gens, input logic stop, input int mode,
                     input bit inject, input int abort_at);
    int   exp_doits;
    logic exp_fx;
    bit   seen_done;
    bit   injected;
    exp_q.delete();
    build_expect(rule, seed, gens, stop, exp_doits, exp_fx);
    ready_mode = mode;
    @(negedge clk);
    init_cnt = 0; doit_cnt = 0; done_cnt = 0;
    start_i = 1'b1; rule_i = rule; seed_i = seed; gens_i = gens; stop_i = stop;
    @(negedge clk); #1;
    start_i = 1'b0;
    rule_i = 8'($urandom); seed_i = W'($urandom); gens_i = G'($urandom); stop_i = ~stop;
    check("load_busy", 32'(busy_o), 32'd1);
    check("load_op_init", 32'(ca_op_o), 32'd0);
    check("latched_rule", 32'(ca_rule_o), 32'(rule));
    check("latched_seed", 32'(ca_seed_o), 32'(seed));
    seen_done = 0; injected = 0;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      @(negedge clk); #1;
      if (injected) start_i = 1'b0;
      if (inject && !injected && out_valid_o) begin
        start_i = 1'b1; rule_i = ~rule; injected = 1;
      end
      if (abort_at != 0 && ca_op_o == 2'd1 && doit_cnt == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done_o) begin
        seen_done = 1;
        check("done_busy_high", 32'(busy_o), 32'd1);
        check("done_fixed", 32'(fixed_o), 32'(exp_fx));
        check("done_rule_kept", 32'(ca_rule_o), 32'(rule));
      end
    end
    start_i = 1'b0;
    check("done_seen", 32'(seen_done), 32'd1);
    @(negedge clk); #1;
    check("idle_busy_low", 32'(busy_o), 32'd0);
    check("idle_op_hold", 32'(ca_op_o), 32'd2);
    check("init_count", 32'(init_cnt), 32'd1);
    check("doit_count", 32'(doit_cnt), 32'(exp_doits));
    check("done_count", 32'(done_cnt), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(8'd150, 8'b0001_0000, 8'd2, 1'b0, 0, 0, 0);
    run(8'd150, 8'b0001_0000, 8'd2, 1'b0, 2, 0, 0);
    run(8'd204, 8'b1010_0101, 8'd5, 1'b1, 0, 0, 0);
    run(8'd204, 8'b1010_0101, 8'd5, 1'b0, 1, 0, 0);
    run(8'($urandom), 8'b1111_0000, 8'd0, 1'b0, 0, 0, 0);
    run(8'd150, 8'b0001_0000, 8'd6, 1'b0, 0, 0, 3);
    run(8'd150, 8'b0001_0000, 8'd2, 1'b0, 0, 0, 0);
    run(8'd30, W'($urandom), 8'd4, 1'b0, 2, 1, 0);
    for (int r = 0; r < 20; r++) begin
      run(8'($urandom), W'($urandom), G'($urandom_range(0, 10)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
